// File: rtl/adc_spi_reader_pkg.sv
// Shared defaults, sclk strobe bundle and width helper for the ADC SPI reader slice.
// Parameters that size counters go through min1_clog2 so a degenerate value still yields a 1-bit vector.
package adc_spi_reader_pkg;

   localparam int ADC_WIDTH_DEFAULT     = 12;
   localparam int LEAD_BITS_DEFAULT     = 3;
   localparam int CLK_DIV_DEFAULT       = 4;
   localparam int SAMPLE_PERIOD_DEFAULT = 1000;

   typedef struct packed {
      logic rise;
      logic fall;
   } sclk_edge_t;

   function automatic int min1_clog2(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/adc_spi_reader_if.sv
// ADC pin bundle plus the published sample/strobe pair.
// The master side is the reader; the slave side is the ADC and downstream consumer.
interface adc_spi_reader_if
   import adc_spi_reader_pkg::*;
#(
   parameter int ADC_WIDTH = ADC_WIDTH_DEFAULT
);

   logic                 adc_cs_n;
   logic                 adc_sclk;
   logic                 adc_miso;
   logic [ADC_WIDTH-1:0] adc_value;
   logic                 adc_value_change;

   modport master (
      output adc_cs_n,
      output adc_sclk,
      input  adc_miso,
      output adc_value,
      output adc_value_change
   );

   modport slave (
      input  adc_cs_n,
      input  adc_sclk,
      output adc_miso,
      input  adc_value,
      input  adc_value_change
   );

endinterface

// File: rtl/adc_spi_reader_sclk_gen.sv
// Serial clock divider: registered sclk toggling every CLK_DIV clk cycles while enabled,
// with combinational rise/fall strobes marking the clk edge that drives each sclk transition.
module adc_sclk_gen
   import adc_spi_reader_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   output logic       sclk,
   output sclk_edge_t edges
);

   localparam int               DIV_W    = min1_clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             half_done;

   assign half_done  = enable && (div_cnt == DIV_LAST);
   assign edges.rise = half_done && !sclk;
   assign edges.fall = half_done && sclk;

   // Dropping enable parks sclk low and rearms the divider for the next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         sclk    <= 1'b0;
      end else if (!enable) begin
         div_cnt <= '0;
         sclk    <= 1'b0;
      end else if (half_done) begin
         div_cnt <= '0;
         sclk    <= ~sclk;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/adc_spi_reader.sv
// Read-only SPI mode-0 ADC front end: idles SAMPLE_PERIOD cycles, clocks one frame of
// LEAD_BITS + ADC_WIDTH bits and publishes the sample with a toggling change strobe.
module adc_spi_reader
   import adc_spi_reader_pkg::*;
#(
   parameter int ADC_WIDTH     = ADC_WIDTH_DEFAULT,
   parameter int LEAD_BITS     = LEAD_BITS_DEFAULT,
   parameter int CLK_DIV       = CLK_DIV_DEFAULT,
   parameter int SAMPLE_PERIOD = SAMPLE_PERIOD_DEFAULT
)
(
   input logic              clk,
   input logic              rst_n,
   adc_spi_reader_if.master bus
);

   localparam int FRAME_BITS = LEAD_BITS + ADC_WIDTH;
   localparam int BIT_W      = $clog2(FRAME_BITS + 1);
   localparam int TIMER_W    = min1_clog2(SAMPLE_PERIOD);

   localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(FRAME_BITS - 1);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SAMPLE_PERIOD - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;

   logic [1:0]           state;
   logic [TIMER_W-1:0]   timer;
   logic [BIT_W-1:0]     fall_cnt;
   logic [ADC_WIDTH-1:0] shift_reg;
   logic [ADC_WIDTH-1:0] value_q;
   logic                 cs_n_q;
   logic                 change_q;
   logic                 sclk;
   logic                 frame_done;
   sclk_edge_t           sclk_edges;

   adc_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (state != ST_IDLE),
      .sclk   (sclk),
      .edges  (sclk_edges)
   );

   assign frame_done = (state == ST_SHIFT) && sclk_edges.fall && (fall_cnt == LAST_BIT);

   // Frame sequencer; the sample is only committed on the final falling sclk, so aborted frames vanish.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         timer    <= '0;
         fall_cnt <= '0;
         cs_n_q   <= 1'b1;
         value_q  <= '0;
         change_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (timer == TIMER_LAST) begin
                  state    <= ST_SETUP;
                  cs_n_q   <= 1'b0;
                  timer    <= '0;
                  fall_cnt <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_SETUP: begin
               if (sclk_edges.rise) begin
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (frame_done) begin
                  state    <= ST_IDLE;
                  cs_n_q   <= 1'b1;
                  value_q  <= shift_reg;
                  change_q <= ~change_q;
                  timer    <= '0;
               end else if (sclk_edges.fall) begin
                  fall_cnt <= fall_cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Lead bits fall off the top of the register, leaving only the last ADC_WIDTH captures.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '0;
      end else if (sclk_edges.rise) begin
         shift_reg <= {shift_reg[ADC_WIDTH-2:0], bus.adc_miso};
      end
   end

   assign bus.adc_cs_n         = cs_n_q;
   assign bus.adc_sclk         = sclk;
   assign bus.adc_value        = value_q;
   assign bus.adc_value_change = change_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench for adc_spi_reader: an SPI slave model feeds queued samples and a
// scoreboard compares each published value, frame timing and strobe polarity.
module tb_adc_spi_reader;

   localparam int ADC_WIDTH     = 12;
   localparam int LEAD_BITS     = 3;
   localparam int CLK_DIV       = 2;
   localparam int SAMPLE_PERIOD = 20;
   localparam int FRAME_BITS    = LEAD_BITS + ADC_WIDTH;
   localparam int FRAME_CYCLES  = 2 * FRAME_BITS * CLK_DIV;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int checks   = 0;
   int failures = 0;

   logic [ADC_WIDTH-1:0]  tx_q[$];
   logic [ADC_WIDTH-1:0]  exp_q[$];
   logic                  expToggle = 1'b0;
   logic                  framing   = 1'b0;
   logic [FRAME_BITS-1:0] slaveShift = '0;
   logic [ADC_WIDTH-1:0]  nextSample;

   adc_spi_reader_if #(.ADC_WIDTH(ADC_WIDTH)) ifc ();

   adc_spi_reader #(
      .ADC_WIDTH     (ADC_WIDTH),
      .LEAD_BITS     (LEAD_BITS),
      .CLK_DIV       (CLK_DIV),
      .SAMPLE_PERIOD (SAMPLE_PERIOD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   // Mode-0 ADC model: loads a frame on cs_n fall, presents the next bit after each sclk fall.
   always @(negedge ifc.adc_cs_n or posedge ifc.adc_cs_n or negedge ifc.adc_sclk) begin
      if (ifc.adc_cs_n !== 1'b0) begin
         framing = 1'b0;
      end else if (!framing) begin
         framing    = 1'b1;
         nextSample = '0;
         if (tx_q.size() > 0) nextSample = tx_q.pop_front();
         exp_q.push_back(nextSample);
         slaveShift = {3'b111, nextSample};
      end else begin
         slaveShift = slaveShift << 1;
      end
   end

   assign ifc.adc_miso = (ifc.adc_cs_n === 1'b0) ? slaveShift[FRAME_BITS-1] : 1'b1;

   // Every comparison in the bench funnels through here so the counters stay in one place.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [ADC_WIDTH-1:0] sample);
      tx_q.push_back(sample);
   endtask

   // Counts clk edges until cs_n falls while watching that the published value holds still.
   task automatic waitCsFall(input string tag, input int expEdges);
      int                   edges;
      logic [ADC_WIDTH-1:0] heldValue;
      logic                 stable;
      edges     = 0;
      heldValue = ifc.adc_value;
      stable    = 1'b1;
      while (ifc.adc_cs_n !== 1'b0 && edges < expEdges + 50) begin
         @(posedge clk);
         #1;
         edges++;
         if (ifc.adc_value !== heldValue) stable = 1'b0;
      end
      checkOutput({tag, "_cs_fall_edges"}, edges, expEdges);
      checkOutput({tag, "_value_stable"}, {31'd0, stable}, 32'd1);
   endtask

   // Follows one frame from just after cs_n fell until cs_n rises, then scores the sample.
   task automatic runFrame(input string tag);
      int                   cycles;
      int                   rises;
      int                   highCycles;
      logic                 prevSclk;
      logic                 earlyToggle;
      logic                 startChange;
      logic [ADC_WIDTH-1:0] expValue;
      cycles      = 0;
      rises       = 0;
      highCycles  = 0;
      prevSclk    = 1'b0;
      earlyToggle = 1'b0;
      startChange = ifc.adc_value_change;
      while (ifc.adc_cs_n === 1'b0 && cycles < FRAME_CYCLES + 20) begin
         @(posedge clk);
         #1;
         cycles++;
         if (ifc.adc_sclk === 1'b1 && prevSclk === 1'b0) rises++;
         if (ifc.adc_sclk === 1'b1) highCycles++;
         if (ifc.adc_cs_n === 1'b0 && ifc.adc_value_change !== startChange) earlyToggle = 1'b1;
         prevSclk = ifc.adc_sclk;
      end
      expToggle = ~expToggle;
      checkOutput({tag, "_cs_low_cycles"}, cycles, FRAME_CYCLES);
      checkOutput({tag, "_sclk_rises"}, rises, FRAME_BITS);
      checkOutput({tag, "_sclk_high_cycles"}, highCycles, FRAME_BITS * CLK_DIV);
      checkOutput({tag, "_no_early_toggle"}, {31'd0, earlyToggle}, 32'd0);
      checkOutput({tag, "_sclk_idle_low"}, {31'd0, ifc.adc_sclk}, 32'd0);
      checkOutput({tag, "_toggle"}, {31'd0, ifc.adc_value_change}, {31'd0, expToggle});
      checkOutput({tag, "_scoreboard_depth"}, exp_q.size(), 1);
      if (exp_q.size() > 0) begin
         expValue = exp_q.pop_front();
         checkOutput({tag, "_value"}, {20'd0, ifc.adc_value}, {20'd0, expValue});
      end
   endtask

   initial begin
      int rises;
      int guard;
      logic prevSclk;

      $display("[TB] reset phase");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_cs_n", {31'd0, ifc.adc_cs_n}, 32'd1);
      checkOutput("reset_sclk", {31'd0, ifc.adc_sclk}, 32'd0);
      checkOutput("reset_value", {20'd0, ifc.adc_value}, 32'd0);
      checkOutput("reset_change", {31'd0, ifc.adc_value_change}, 32'd0);

      applyStimulus(12'hABC);
      applyStimulus(12'hFFF);
      applyStimulus(12'h000);
      applyStimulus(12'h3C5);
      applyStimulus(12'h5A3);

      @(negedge clk);
      rst_n = 1'b1;
      waitCsFall("first", SAMPLE_PERIOD);
      runFrame("frame_abc");

      waitCsFall("gap1", SAMPLE_PERIOD);
      runFrame("frame_fff");
      waitCsFall("gap2", SAMPLE_PERIOD);
      runFrame("frame_000");

      $display("[TB] mid-frame reset");
      waitCsFall("gap3", SAMPLE_PERIOD);
      rises    = 0;
      guard    = 0;
      prevSclk = 1'b0;
      while (rises < 7 && guard < FRAME_CYCLES) begin
         @(posedge clk);
         #1;
         guard++;
         if (ifc.adc_sclk === 1'b1 && prevSclk === 1'b0) rises++;
         prevSclk = ifc.adc_sclk;
      end
      checkOutput("midreset_reached_rise7", rises, 7);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_cs_n", {31'd0, ifc.adc_cs_n}, 32'd1);
      checkOutput("midreset_sclk", {31'd0, ifc.adc_sclk}, 32'd0);
      checkOutput("midreset_value", {20'd0, ifc.adc_value}, 32'd0);
      checkOutput("midreset_change", {31'd0, ifc.adc_value_change}, 32'd0);
      exp_q.delete();
      expToggle = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      waitCsFall("post_reset", SAMPLE_PERIOD);
      runFrame("frame_5a3");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
